alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU (IDLE -> EXEC -> RESP).
// Optional illegal-op flagging on rsp_err is enabled by defining ALU_ARB_ILLEGAL_OP_EN.
module alu_arbiter #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [size-1:0] req0_a,
    input  logic [size-1:0] req0_b,
    input  logic [2:0]      req0_func,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [size-1:0] req1_a,
    input  logic [size-1:0] req1_b,
    input  logic [2:0]      req1_func,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [size-1:0] rsp_data,
    output logic            rsp_zero,
    output logic            rsp_id,
    output logic            rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic [size-1:0] r_a;
    logic [size-1:0] r_b;
    logic [2:0]      r_func;
    logic            r_id;
    logic            r_rsp_valid;
    logic [size-1:0] r_rsp_data;
    logic            r_rsp_zero;
    logic            r_rsp_id;

    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [size-1:0] w_result;

    assign w_idle = (r_state == IDLE) && !rst;

    // r_last is the last served requester; on contention the other one wins.
    assign w_gnt0 = w_idle && req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = w_idle && req1_valid && (!req0_valid || !r_last);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        w_result = '0;
        case (r_func)
            3'd0: w_result = r_a + r_b;
            3'd1: w_result = r_a - r_b;
            3'd2: w_result = r_a & r_b;
            3'd3: w_result = r_a | r_b;
            3'd4: w_result = ~(r_a | r_b);
            3'd5: w_result = {{(size-1){1'b0}}, (r_a < r_b)};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_func      <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a     <= w_gnt1 ? req1_a    : req0_a;
                        r_b     <= w_gnt1 ? req1_b    : req0_b;
                        r_func  <= w_gnt1 ? req1_func : req0_func;
                        r_id    <= w_gnt1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_zero  <= (w_result == '0);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_last      <= r_rsp_id;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= r_func[2] & r_func[1];
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle
// plus hand-computed literal expectations for the named scenarios.
module tb_alu_arbiter;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_func, req1_func;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_id, rsp_err;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.size(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Transaction model: a response appears two cycles after the accept and
    // stays until taken; outputs otherwise hold the last delivered response.
    bit          m_known = 0;
    bit          m_busy  = 0;
    int          m_cnt   = 0;
    bit          m_last  = 1;
    logic [31:0] m_exp_data, m_hold_data;
    logic        m_exp_zero, m_exp_id, m_exp_err;
    logic        m_hold_zero, m_hold_id, m_hold_err;

    always @(negedge clk) begin
        automatic bit e_r0 = !rst && !m_busy && req0_valid && (!req1_valid || m_last);
        automatic bit e_r1 = !rst && !m_busy && req1_valid && (!req0_valid || !m_last);
        automatic bit e_v  = m_busy && (m_cnt == 2);
        if (m_known) begin
            chk("cyc_req0_ready", req0_ready, e_r0);
            chk("cyc_req1_ready", req1_ready, e_r1);
            chk("cyc_rsp_valid", rsp_valid, e_v);
            chk("cyc_rsp_data", rsp_data, e_v ? m_exp_data : m_hold_data);
            chk("cyc_rsp_zero", rsp_zero, e_v ? m_exp_zero : m_hold_zero);
            chk("cyc_rsp_id",   rsp_id,   e_v ? m_exp_id   : m_hold_id);
            chk("cyc_rsp_err",  rsp_err,  e_v ? m_exp_err  : m_hold_err);
        end
        if (rst) begin
            m_known = 1; m_busy = 0; m_cnt = 0; m_last = 1;
            m_hold_data = '0; m_hold_zero = 0; m_hold_id = 0; m_hold_err = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_exp_data = e_r1 ? alu_ref(req1_func, req1_a, req1_b) : alu_ref(req0_func, req0_a, req0_b);
                    m_exp_zero = (m_exp_data == 0);
                    m_exp_id   = e_r1;
                    m_exp_err  = ILL && ((e_r1 ? req1_func : req0_func) >= 3'd6);
                    m_busy = 1; m_cnt = 1;
                end
            end else if (m_cnt == 1) begin
                m_cnt = 2;
            end else if (rsp_ready) begin
                m_busy = 0; m_cnt = 0; m_last = m_exp_id;
                m_hold_data = m_exp_data; m_hold_zero = m_exp_zero;
                m_hold_id = m_exp_id; m_hold_err = m_exp_err;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (id) begin req1_valid = 1; req1_func = f; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_func = f; req0_a = a; req0_b = b; end
    endtask

    // Single uncontended transaction with rsp_ready high; starts and ends idle.
    task automatic run_single(input string tag, input bit id, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e_d, input bit e_z, input bit e_e);
        step();
        set_req(id, f, a, b);
        @(negedge clk);
        chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
        step();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk({tag, "_exec_valid"}, rsp_valid, 1'b0);
        step();
        @(negedge clk);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, e_d);
        chk({tag, "_zero"}, rsp_zero, e_z);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_err"}, rsp_err, e_e);
        step();
        $display("txn %s id=%0d func=%0d a=%0h b=%0h data=%0h", tag, id, f, a, b, e_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   g[3];
        int   ng, nr;
        bit   exp_g[3];
        rst = 1; rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_a = 0; req0_b = 0; req0_func = 0;
        req1_a = 0; req1_b = 0; req1_func = 0;

        // Reset state, and readies stay low while rst is high.
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_zero", rsp_zero, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        step();
        req0_valid = 0; req1_valid = 0; rst = 0;

        run_single("t1_add", 0, 3'd0, 32'd5, 32'd3, 32'd8, 0, 0);

        // Both requesters valid continuously after a reset: grants 0,1,0.
        rst = 1; step(); step(); rst = 0;
        set_req(0, 3'd1, 32'd7, 32'd7);
        set_req(1, 3'd3, 32'hF0, 32'h0F);
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0;
        ng = 0; nr = 0;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && ng < 3) begin
                g[ng] = req1_ready;
                ng++;
            end
            if (rsp_valid) begin
                chk("t2_rsp_id", rsp_id, exp_g[nr]);
                chk("t2_rsp_data", rsp_data, rsp_id ? 32'hFF : 32'h0);
                chk("t2_rsp_zero", rsp_zero, rsp_id ? 1'b0 : 1'b1);
                $display("txn t2 id=%0d data=%0h", rsp_id, rsp_data);
                nr++;
            end
            if (nr < 3) step();
        end
        chk("t2_responses", nr, 3);
        chk("t2_grants", ng, 3);
        for (int i = 0; i < 3; i++) chk("t2_grant_order", g[i], exp_g[i]);
        step();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;

        // Stalled response: stable 5 cycles, no accept even with req0 pending.
        step();
        set_req(1, 3'd5, 32'hFFFFFFFF, 32'd1);
        @(negedge clk);
        chk("t3_ready", req1_ready, 1'b1);
        step();
        req1_valid = 0;
        set_req(0, 3'd0, 32'd2, 32'd2);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_valid", rsp_valid, 1'b1);
            chk("t3_data", rsp_data, 32'd0);
            chk("t3_zero", rsp_zero, 1'b1);
            chk("t3_id", rsp_id, 1'b1);
            chk("t3_no_accept", req0_ready, 1'b0);
            step();
            if (k == 3) rsp_ready = 1;
        end
        $display("txn t3 id=1 func=5 data=0 stalled=4");
        @(negedge clk);
        chk("t3_pending_ready", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        step(); step(); step();

        run_single("t4_op7", 0, 3'd7, 32'd1, 32'd1, 32'd0, 1, ILL);
        run_single("t4_op6", 1, 3'd6, 32'd9, 32'd4, 32'd0, 1, ILL);
        run_single("t5_wrap", 0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
        run_single("sub", 1, 3'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0);
        run_single("and", 0, 3'd2, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
        run_single("nor", 1, 3'd4, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_single("slt", 0, 3'd5, 32'd1, 32'd2, 32'd1, 0, 0);

        // Reset while in EXEC discards the operation and re-prefers requester 0.
        step();
        set_req(0, 3'd0, 32'd1, 32'd1);
        @(negedge clk);
        chk("t6_ready", req0_ready, 1'b1);
        step();
        req0_valid = 0; rst = 1;
        @(negedge clk);
        chk("t6_rst_ready0", req0_ready, 1'b0);
        chk("t6_rst_ready1", req1_ready, 1'b0);
        step();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_valid", rsp_valid, 1'b0);
            chk("t6_data", rsp_data, 32'd0);
            chk("t6_zero", rsp_zero, 1'b0);
            chk("t6_id", rsp_id, 1'b0);
            chk("t6_err", rsp_err, 1'b0);
            step();
        end
        set_req(0, 3'd0, 32'd2, 32'd3);
        set_req(1, 3'd3, 32'd4, 32'd1);
        @(negedge clk);
        chk("t6_grant0", req0_ready, 1'b1);
        chk("t6_grant1", req1_ready, 1'b0);
        step();
        req0_valid = 0;
        step(); step(); step(); step(); step(); step();
        req1_valid = 0;
        step(); step();
        $display("txn t6 reset-in-exec done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
